branch_resolve_bht: RTL and testbench
=====================================

Name: branch_resolve_bht

Overview:
- Parametrised successor to the combinational branch comparator.
- Resolves branch conditions in execute and registers the outcome with 1-cycle latency.
- Detects mispredicts against the fetch-time prediction and produces a redirect PC.
- Owns a direct-mapped branch history table (BHT) of 2-bit saturating counters that supplies fetch-time predictions.

Parameters:
- XLEN, 32, operand/PC width; the instantiating level passes `RF_XLEN.
- BHT_ENTRIES, 64, number of BHT counters; power of 2, ≥2.
- IDX_W, $clog2(BHT_ENTRIES), BHT index width; derived, not overridden.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- pred_pc  in  XLEN  fetch PC to predict.
- pred_taken  out  1  prediction for pred_pc; combinational = BHT[idx(pred_pc)][1].
- res_valid  in  1  resolve request this cycle.
- res_pc  in  XLEN  PC of the branch being resolved.
- res_br_op  in  `BR_OPSLEN  branch operation code (`BR_OPS_*).
- res_a, res_b  in  XLEN each  compare operands.
- res_target  in  XLEN  computed taken target.
- res_pred_taken  in  1  prediction that fetch used for this branch.
- flush  in  1  kill the request presented this cycle.
- out_valid  out  1  registered result valid.
- out_taken  out  1  actual outcome.
- out_mispredict  out  1  outcome ≠ res_pred_taken.
- out_redirect_pc  out  XLEN  correct next PC; meaningful only when out_mispredict=1.

Behaviour:
- idx(pc) = pc[IDX_W+1:2]; pc[1:0] ignored.
- Condition evaluation:
  - EQ/NE/LTU/GEU: unsigned compares on the full XLEN.
  - LT/GE: signed compares.
  - UNCOND: taken = 1.
  - Any other code: taken = 0.
- Request acceptance: a request is accepted when res_valid=1 and flush=0. Next cycle:
  - out_valid=1.
  - out_taken = evaluated condition.
  - out_mispredict = out_taken ^ res_pred_taken.
  - out_redirect_pc = res_target if taken, else res_pc+4 (mod 2^XLEN).
- Non-accepted cycle: out_valid=0 next cycle. out_taken, out_mispredict and out_redirect_pc also clear to 0.
- Outputs are registered, with no combinational path from res_* to out_*. Throughput is 1 request per cycle; there is no backpressure.
- BHT update on an accepted request, only for the six conditional ops (EQ..GEU):
  - Taken: counter += 1, saturating at 2'b11.
  - Not taken: counter -= 1, saturating at 2'b00.
  - UNCOND and unknown codes do not update the BHT.
- Update timing: the BHT write occurs at the same clock edge that registers the outputs.
- Same-cycle read/write: if pred_pc and res_pc map to the same index in one cycle, pred_taken returns the pre-update value. This is read-before-write; there is no bypass.
- Reset (rst=1 at a clock edge):
  - All outputs clear to 0.
  - Every BHT counter is set to 2'b01 (weakly not-taken).
  - Any in-flight request is dropped.
  - pred_taken reads 0 from the first cycle after reset.
- flush together with res_valid: the request is discarded, with no output and no BHT update. flush has no effect on a result that is already registered.

Optional Feature:
- BR_PERF_CNT_EN
- Defined: adds outputs perf_branches (32-bit) and perf_mispredicts (32-bit).
  - perf_branches increments on every accepted request.
  - perf_mispredicts increments on every accepted request that mispredicts.
  - Both wrap modulo 2^32 and reset to 0.
- Undefined: ports and counters are absent. All other behaviour is unchanged.

Test Plan:
- Reset, then pred_pc=0x100 → pred_taken=0. BEQ a=b=5, res_pred_taken=0 → next cycle out_valid=1, out_taken=1, out_mispredict=1, out_redirect_pc=res_target.
- Signed/unsigned compares:
  - BLT a=0xFFFFFFFF, b=1 → taken=1.
  - BLTU same operands → taken=0, redirect_pc=res_pc+4.
  - BGE a=b → taken=1.
- Saturation at res_pc=0x40:
  - Three taken BNEs → counter 11, pred_taken(0x40)=1.
  - One not-taken → counter 10, still 1.
  - Two more not-taken → counter 00, pred_taken=0.
- Aliasing and read-before-write (BHT_ENTRIES=64): resolve a taken branch at 0x40 while pred_pc=0x140 (same idx) in the same cycle → pred_taken shows the old value that cycle and the new value the next.
- Kill and reset:
  - UNCOND at res_pc=0xFFFFFFFC → taken, redirect=target, BHT unchanged.
  - flush with res_valid → out_valid=0, BHT unchanged.
  - rst asserted the cycle after a request → outputs 0 and counters back to 01.
- With BR_PERF_CNT_EN: 10 branches including 3 mispredicts, 1 flushed → perf_branches=9, perf_mispredicts=3. Preset near 0xFFFFFFFF → counters wrap to 0.

Source files
------------

// File: rtl/branch_resolve_bht.sv
// Execute-stage branch resolver with a 2-bit-counter BHT for fetch prediction.
// Optional BR_PERF_CNT_EN adds branch/mispredict event counters.
`ifndef RF_XLEN
`define RF_XLEN 32
`endif
`ifndef BR_OPSLEN
`define BR_OPSLEN 3
`endif
`ifndef BR_OPS_EQ
`define BR_OPS_EQ     3'd0
`define BR_OPS_NE     3'd1
`define BR_OPS_LT     3'd2
`define BR_OPS_GE     3'd3
`define BR_OPS_LTU    3'd4
`define BR_OPS_GEU    3'd5
`define BR_OPS_UNCOND 3'd6
`endif

module branch_resolve_bht #(
  parameter int XLEN        = `RF_XLEN,
  parameter int BHT_ENTRIES = 64,
  localparam int IDX_W      = $clog2(BHT_ENTRIES)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [XLEN-1:0]       pred_pc,
  output logic                  pred_taken,
  input  logic                  res_valid,
  input  logic [XLEN-1:0]       res_pc,
  input  logic [`BR_OPSLEN-1:0] res_br_op,
  input  logic [XLEN-1:0]       res_a,
  input  logic [XLEN-1:0]       res_b,
  input  logic [XLEN-1:0]       res_target,
  input  logic                  res_pred_taken,
  input  logic                  flush,
`ifdef BR_PERF_CNT_EN
  output logic [31:0]           perf_branches,
  output logic [31:0]           perf_mispredicts,
`endif
  output logic                  out_valid,
  output logic                  out_taken,
  output logic                  out_mispredict,
  output logic [XLEN-1:0]       out_redirect_pc
);

  typedef struct packed {
    logic            vld;
    logic            taken;
    logic            mispredict;
    logic [XLEN-1:0] redirect;
  } res_t;

  res_t             res_d, res_q;
  logic [1:0]       bht_q [BHT_ENTRIES];
  logic [IDX_W-1:0] pred_idx, res_idx;
  logic             accept, taken, cond_op, upd;
  logic [1:0]       cnt, cnt_d;
  logic             unused_pc_bits;

  assign pred_idx       = pred_pc[IDX_W+1:2];
  assign res_idx        = res_pc[IDX_W+1:2];
  assign unused_pc_bits = ^{pred_pc[XLEN-1:IDX_W+2], pred_pc[1:0]};

  // Read-before-write: prediction always reflects the registered table.
  assign pred_taken = bht_q[pred_idx][1];

  always_comb begin
    taken   = 1'b0;
    cond_op = 1'b1;
    case (res_br_op)
      `BR_OPS_EQ:     taken = (res_a == res_b);
      `BR_OPS_NE:     taken = (res_a != res_b);
      `BR_OPS_LT:     taken = ($signed(res_a) <  $signed(res_b));
      `BR_OPS_GE:     taken = ($signed(res_a) >= $signed(res_b));
      `BR_OPS_LTU:    taken = (res_a <  res_b);
      `BR_OPS_GEU:    taken = (res_a >= res_b);
      `BR_OPS_UNCOND: begin taken = 1'b1; cond_op = 1'b0; end
      default:        cond_op = 1'b0;
    endcase
  end

  assign accept = res_valid & ~flush;
  assign upd    = accept & cond_op;
  assign cnt    = bht_q[res_idx];

  always_comb begin
    cnt_d = cnt;
    if (taken && cnt != 2'b11)       cnt_d = cnt + 2'd1;
    else if (!taken && cnt != 2'b00) cnt_d = cnt - 2'd1;
  end

  always_comb begin
    res_d = '0;
    if (accept) begin
      res_d.vld        = 1'b1;
      res_d.taken      = taken;
      res_d.mispredict = taken ^ res_pred_taken;
      res_d.redirect   = taken ? res_target : res_pc + XLEN'(4);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      res_q <= '0;
      for (int i = 0; i < BHT_ENTRIES; i++) bht_q[i] <= 2'b01;
    end else begin
      res_q <= res_d;
      if (upd) bht_q[res_idx] <= cnt_d;
    end
  end

  assign out_valid       = res_q.vld;
  assign out_taken       = res_q.taken;
  assign out_mispredict  = res_q.mispredict;
  assign out_redirect_pc = res_q.redirect;

`ifdef BR_PERF_CNT_EN
  logic [31:0] perf_br_q, perf_mp_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_br_q <= '0;
      perf_mp_q <= '0;
    end else if (accept) begin
      perf_br_q <= perf_br_q + 32'd1;
      if (res_d.mispredict) perf_mp_q <= perf_mp_q + 32'd1;
    end
  end

  assign perf_branches    = perf_br_q;
  assign perf_mispredicts = perf_mp_q;
`endif

endmodule

// File: tb/tb_branch_resolve_bht.sv
// Directed plus randomized bench for branch_resolve_bht against a table-level model.
module tb_branch_resolve_bht;
  localparam int OP_EQ = 0, OP_NE = 1, OP_LT = 2, OP_GE = 3, OP_LTU = 4, OP_GEU = 5, OP_UNC = 6, OP_BAD = 7;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pred_pc = '0;
  logic        pred_taken;
  logic        res_valid = 1'b0;
  logic [31:0] res_pc = '0;
  logic [2:0]  res_br_op = '0;
  logic [31:0] res_a = '0, res_b = '0, res_target = '0;
  logic        res_pred_taken = 1'b0;
  logic        flush = 1'b0;
  logic        out_valid, out_taken, out_mispredict;
  logic [31:0] out_redirect_pc;
`ifdef BR_PERF_CNT_EN
  logic [31:0] perf_branches, perf_mispredicts;
`endif

  branch_resolve_bht dut (
    .clk(clk), .rst(rst), .pred_pc(pred_pc), .pred_taken(pred_taken),
    .res_valid(res_valid), .res_pc(res_pc), .res_br_op(res_br_op),
    .res_a(res_a), .res_b(res_b), .res_target(res_target),
    .res_pred_taken(res_pred_taken), .flush(flush),
`ifdef BR_PERF_CNT_EN
    .perf_branches(perf_branches), .perf_mispredicts(perf_mispredicts),
`endif
    .out_valid(out_valid), .out_taken(out_taken),
    .out_mispredict(out_mispredict), .out_redirect_pc(out_redirect_pc)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int model_bht [64];
  longint model_br = 0, model_mp = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int idx_of(input logic [31:0] pc);
    return int'((longint'(pc) / 4) % 64);
  endfunction

  function automatic longint as_signed(input logic [31:0] v);
    return (longint'(v) >= 64'sd2147483648) ? longint'(v) - 64'sd4294967296 : longint'(v);
  endfunction

  function automatic bit ref_taken(input int op, input logic [31:0] a, input logic [31:0] b);
    longint ua = longint'(a), ub = longint'(b);
    case (op)
      OP_EQ:  return ua == ub;
      OP_NE:  return ua != ub;
      OP_LT:  return as_signed(a) <  as_signed(b);
      OP_GE:  return as_signed(a) >= as_signed(b);
      OP_LTU: return ua <  ub;
      OP_GEU: return ua >= ub;
      OP_UNC: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // One cycle: drive at negedge, check prediction before the edge, outputs after.
  task automatic step(input bit v, input bit fl, input bit r, input logic [31:0] pc, input int op,
                      input logic [31:0] a, input logic [31:0] b, input logic [31:0] tgt,
                      input bit rp, input logic [31:0] ppc, input string tag);
    bit acc, tk, e_tk, e_mp;
    logic [31:0] e_rd;
    res_valid = v; flush = fl; rst = r; res_pc = pc; res_br_op = 3'(op);
    res_a = a; res_b = b; res_target = tgt; res_pred_taken = rp; pred_pc = ppc;
    #1;
    chk({tag, ".pred"}, {63'd0, pred_taken}, {63'd0, model_bht[idx_of(ppc)] >= 2});
    acc = v && !fl && !r;
    tk = ref_taken(op, a, b);
    e_tk = acc && tk;
    e_mp = acc && (tk != rp);
    e_rd = !acc ? 32'd0 : tk ? tgt : 32'((longint'(pc) + 4) % 64'd4294967296);
    if (r) begin
      foreach (model_bht[i]) model_bht[i] = 1;
      model_br = 0; model_mp = 0;
    end else if (acc) begin
      model_br++;
      if (tk != rp) model_mp++;
      if (op <= OP_GEU) begin
        if (tk) model_bht[idx_of(pc)] = (model_bht[idx_of(pc)] == 3) ? 3 : model_bht[idx_of(pc)] + 1;
        else    model_bht[idx_of(pc)] = (model_bht[idx_of(pc)] == 0) ? 0 : model_bht[idx_of(pc)] - 1;
      end
    end
    @(posedge clk); #1;
    chk({tag, ".valid"}, {63'd0, out_valid}, {63'd0, acc});
    chk({tag, ".taken"}, {63'd0, out_taken}, {63'd0, e_tk});
    chk({tag, ".misp"},  {63'd0, out_mispredict}, {63'd0, e_mp});
    chk({tag, ".redir"}, {32'd0, out_redirect_pc}, {32'd0, e_rd});
`ifdef BR_PERF_CNT_EN
    chk({tag, ".pbr"}, {32'd0, perf_branches},    64'(model_br % 64'd4294967296));
    chk({tag, ".pmp"}, {32'd0, perf_mispredicts}, 64'(model_mp % 64'd4294967296));
`endif
    @(negedge clk);
  endtask

  task automatic idle(input logic [31:0] ppc, input string tag);
    step(0, 0, 0, 32'h0, OP_EQ, 0, 0, 0, 0, ppc, tag);
  endtask

  initial begin
    foreach (model_bht[i]) model_bht[i] = 1;
    @(negedge clk);
    step(0, 0, 1, 32'h0, OP_EQ, 0, 0, 0, 0, 32'h100, "rst0");
    step(0, 0, 1, 32'h0, OP_EQ, 0, 0, 0, 0, 32'h100, "rst1");
    idle(32'h100, "post_rst");

    step(1, 0, 0, 32'h100, OP_EQ, 5, 5, 32'h200, 0, 32'h100, "beq");
    step(1, 0, 0, 32'h80, OP_LT,  32'hFFFFFFFF, 1, 32'h300, 0, 32'h80, "blt");
    step(1, 0, 0, 32'h84, OP_LTU, 32'hFFFFFFFF, 1, 32'h300, 1, 32'h84, "bltu");
    step(1, 0, 0, 32'h88, OP_GE,  7, 7, 32'h400, 0, 32'h88, "bge");
    step(1, 0, 0, 32'h8C, OP_GEU, 0, 32'h80000000, 32'h400, 0, 32'h8C, "bgeu");

    for (int i = 0; i < 3; i++) step(1, 0, 0, 32'h40, OP_NE, 1, 2, 32'h500, 1, 32'h40, "bne_t");
    idle(32'h40, "sat11");
    step(1, 0, 0, 32'h40, OP_NE, 3, 3, 32'h500, 1, 32'h40, "bne_n1");
    idle(32'h40, "cnt10");
    for (int i = 0; i < 2; i++) step(1, 0, 0, 32'h40, OP_NE, 3, 3, 32'h500, 1, 32'h40, "bne_n");
    idle(32'h40, "sat00");
    step(1, 0, 0, 32'h40, OP_NE, 3, 3, 32'h500, 0, 32'h40, "bne_floor");

    step(1, 0, 0, 32'h40, OP_EQ, 9, 9, 32'h600, 0, 32'h140, "alias0");
    step(1, 0, 0, 32'h40, OP_EQ, 9, 9, 32'h600, 0, 32'h140, "alias1");
    idle(32'h140, "alias_new");

    step(1, 0, 0, 32'hFFFFFFFC, OP_UNC, 0, 1, 32'h1000, 0, 32'hFFFFFFFC, "uncond");
    idle(32'hFFFFFFFC, "uncond_bht");
    step(1, 0, 0, 32'hFFFFFFFC, OP_BAD, 4, 4, 32'h1000, 1, 32'hFFFFFFFC, "badop_wrap");
    step(1, 1, 0, 32'h40, OP_EQ, 1, 1, 32'h700, 0, 32'h40, "flush");
    idle(32'h40, "flush_bht");

    step(1, 0, 0, 32'h44, OP_EQ, 1, 1, 32'h800, 0, 32'h44, "pre_rst");
    step(1, 0, 1, 32'h40, OP_EQ, 1, 1, 32'h800, 0, 32'h40, "rst_mid");
    idle(32'h40, "rst_clear");
    step(1, 0, 0, 32'h40, OP_EQ, 1, 1, 32'h800, 0, 32'h40, "rst_01");
    idle(32'h40, "rst_01_chk");

    for (int n = 0; n < 300; n++) begin
      logic [31:0] a, b, pc, ppc;
      int op;
      a   = $urandom;
      b   = ($urandom_range(0, 3) == 0) ? a : $urandom;
      pc  = {$urandom_range(0, 3) == 0 ? $urandom : 32'h0} ^ 32'($urandom_range(0, 15) * 4);
      ppc = 32'($urandom_range(0, 15) * 4) + 32'(($urandom_range(0, 3)) << 8);
      op  = $urandom_range(0, 7);
      step($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0, $urandom_range(0, 63) == 0,
           pc, op, a, b, $urandom, $urandom_range(0, 1), ppc, "rand");
    end

`ifdef BR_PERF_CNT_EN
    step(0, 0, 1, 32'h0, OP_EQ, 0, 0, 0, 0, 32'h0, "prst");
    for (int n = 0; n < 10; n++)
      step(1, n == 9, 0, 32'h200 + 32'(n * 4), OP_EQ, 1, 1, 32'h900, (n < 3) ? 1'b0 : 1'b1, 32'h0, "perf");
    chk("perf_br9", {32'd0, perf_branches}, 64'd9);
    chk("perf_mp3", {32'd0, perf_mispredicts}, 64'd3);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
